// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control sequencer for a small RV32I-style core.
// It walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Memory handshakes are guarded by a wait counter, and every fault lands in
// an absorbing TRAP state. All outputs are decoded from registered state, so
// op_code has no combinational path to any output.
module ctrl_fsm #(
    parameter int OP_CODE_SIZE = 7,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_CODE_SIZE-1:0] op_code,
    input  logic                    branch_taken,
    input  logic                    imem_ack,
    input  logic                    dmem_ack,
    output logic                    imem_req,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic                    ir_en,
    output logic                    pc_en,
    output logic [1:0]              pc_src,
    output logic                    rf_we,
    output logic [1:0]              wb_sel,
    output logic                    trap,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LUI    = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_JAL    = 4'd3,
        CLS_JALR   = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LOAD   = 4'd6,
        CLS_STORE  = 4'd7,
        CLS_OPIMM  = 4'd8,
        CLS_OP     = 4'd9
    } cls_t;

    localparam logic [OP_CODE_SIZE-1:0] OPC_LUI    = OP_CODE_SIZE'(7'b0110111);
    localparam logic [OP_CODE_SIZE-1:0] OPC_AUIPC  = OP_CODE_SIZE'(7'b0010111);
    localparam logic [OP_CODE_SIZE-1:0] OPC_JAL    = OP_CODE_SIZE'(7'b1101111);
    localparam logic [OP_CODE_SIZE-1:0] OPC_JALR   = OP_CODE_SIZE'(7'b1100111);
    localparam logic [OP_CODE_SIZE-1:0] OPC_BRANCH = OP_CODE_SIZE'(7'b1100011);
    localparam logic [OP_CODE_SIZE-1:0] OPC_LOAD   = OP_CODE_SIZE'(7'b0000011);
    localparam logic [OP_CODE_SIZE-1:0] OPC_STORE  = OP_CODE_SIZE'(7'b0100011);
    localparam logic [OP_CODE_SIZE-1:0] OPC_OPIMM  = OP_CODE_SIZE'(7'b0010011);
    localparam logic [OP_CODE_SIZE-1:0] OPC_OP     = OP_CODE_SIZE'(7'b0110011);

    localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    state_t            r_state;
    cls_t              r_cls;
    logic [WAIT_W-1:0] r_wait;
    logic              r_run;

    state_t            w_nextState;
    cls_t              w_decCls;
    logic [WAIT_W-1:0] w_waitInc;
    logic              w_timeout;

    // r_run holds requests off until the first edge after reset is released
    assign w_waitInc = r_wait + WAIT_W'(1);
    assign w_timeout = (w_waitInc == WAIT_LIMIT);
    assign state     = r_state;

    // Classify the incoming opcode; only consumed while in DECODE
    always_comb begin
        w_decCls = CLS_NONE;
        case (op_code)
            OPC_LUI:    w_decCls = CLS_LUI;
            OPC_AUIPC:  w_decCls = CLS_AUIPC;
            OPC_JAL:    w_decCls = CLS_JAL;
            OPC_JALR:   w_decCls = CLS_JALR;
            OPC_BRANCH: w_decCls = CLS_BRANCH;
            OPC_LOAD:   w_decCls = CLS_LOAD;
            OPC_STORE:  w_decCls = CLS_STORE;
            OPC_OPIMM:  w_decCls = CLS_OPIMM;
            OPC_OP:     w_decCls = CLS_OP;
            default:    w_decCls = CLS_NONE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Wait counter, latched class and run flag; counter restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run  <= 1'b0;
            r_wait <= '0;
            r_cls  <= CLS_NONE;
        end else begin
            r_run <= 1'b1;
            if (w_nextState != r_state) begin
                r_wait <= '0;
            end else if (r_run && (r_state == S_FETCH || r_state == S_MEM)) begin
                r_wait <= w_waitInc;
            end
            if (r_state == S_DECODE) begin
                r_cls <= w_decCls;
            end
        end
    end

    // Next-state logic; an ack in the timeout cycle takes priority over the trap
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (r_run) begin
                    if (imem_ack) begin
                        w_nextState = S_DECODE;
                    end else if (w_timeout) begin
                        w_nextState = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                w_nextState = (w_decCls == CLS_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                w_nextState = (r_cls == CLS_LOAD || r_cls == CLS_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    w_nextState = S_WB;
                end else if (w_timeout) begin
                    w_nextState = S_TRAP;
                end
            end
            S_WB:    w_nextState = S_FETCH;
            S_TRAP:  w_nextState = S_TRAP;
            default: w_nextState = S_TRAP;
        endcase
    end

    // Output decode from registered state and latched class
    always_comb begin
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_en    = 1'b0;
        pc_src   = 2'd0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        trap     = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = r_run;
                ir_en    = r_run & imem_ack;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == CLS_STORE);
            end
            S_WB: begin
                pc_en = 1'b1;
                rf_we = !(r_cls == CLS_BRANCH || r_cls == CLS_STORE);
                if (r_cls == CLS_LOAD) begin
                    wb_sel = 2'd1;
                end else if (r_cls == CLS_JAL || r_cls == CLS_JALR) begin
                    wb_sel = 2'd2;
                end
                if (r_cls == CLS_JAL || (r_cls == CLS_BRANCH && branch_taken)) begin
                    pc_src = 2'd1;
                end else if (r_cls == CLS_JALR) begin
                    pc_src = 2'd2;
                end
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: self-checking bench for ctrl_fsm. Each instruction is run
// through the DUT with scripted ack delays, and its observed behaviour
// (latency, strobes, write-back controls, trap) is compared with either a
// hand-written table or an instruction-level reference model.
module tb_ctrl_fsm;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_code;
    logic       branch_taken;
    logic       imem_ack;
    logic       dmem_ack;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       trap;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit trap;
        int cycles;
        int irCnt;
        bit rfWe;
        int wbSel;
        int pcSrc;
        int memCycles;
        int weCycles;
    } result_t;

    typedef struct {
        logic [6:0] opc;
        int         iWait;
        int         dWait;
        logic       bt;
        result_t    exp;
    } vec_t;

    ctrl_fsm #(.OP_CODE_SIZE(7), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_code      (op_code),
        .branch_taken (branch_taken),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_en        (ir_en),
        .pc_en        (pc_en),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .state        (state)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded loops
    initial begin
        #400000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic vec_t mkVec(input logic [6:0] opc, input int iw, input int dw, input logic bt,
                                   input bit tr, input int cyc, input bit rf, input int wb,
                                   input int pc, input int mem, input int we);
        vec_t v;
        v.opc = opc;
        v.iWait = iw;
        v.dWait = dw;
        v.bt = bt;
        v.exp.trap = tr;
        v.exp.cycles = cyc;
        v.exp.irCnt = tr ? 0 : 1;
        v.exp.rfWe = rf;
        v.exp.wbSel = wb;
        v.exp.pcSrc = pc;
        v.exp.memCycles = mem;
        v.exp.weCycles = we;
        return v;
    endfunction

    // Instruction-level reference: class tables plus latency arithmetic
    function automatic result_t expectModel(input logic [6:0] opc, input int iWait, input int dWait,
                                            input logic bt);
        logic [6:0] legalOps[9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        int rfTbl[9]  = '{1, 1, 1, 1, 0, 1, 0, 1, 1};
        int wbTbl[9]  = '{0, 0, 2, 2, 0, 1, 0, 0, 0};
        int pcTbl[9]  = '{0, 0, 1, 2, 0, 0, 0, 0, 0};
        int memTbl[9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        int idx = -1;
        int memCyc;
        result_t r;
        for (int i = 0; i < 9; i++) begin
            if (opc == legalOps[i]) idx = i;
        end
        r.trap = 0; r.cycles = 0; r.irCnt = 0; r.rfWe = 0;
        r.wbSel = 0; r.pcSrc = 0; r.memCycles = 0; r.weCycles = 0;
        if (iWait >= TIMEOUT) begin
            r.trap = 1;
            r.cycles = TIMEOUT + 1;
        end else if (idx < 0) begin
            r.trap = 1;
            r.cycles = iWait + 3;
        end else if (memTbl[idx] == 1 && dWait >= TIMEOUT) begin
            r.trap = 1;
            r.cycles = iWait + TIMEOUT + 4;
        end else begin
            memCyc = (memTbl[idx] == 1) ? dWait + 1 : 0;
            r.cycles = iWait + 4 + memCyc;
            r.irCnt = 1;
            r.rfWe = (rfTbl[idx] == 1);
            r.wbSel = wbTbl[idx];
            r.pcSrc = (idx == 4) ? (bt ? 1 : 0) : pcTbl[idx];
            r.memCycles = memCyc;
            r.weCycles = (idx == 6) ? memCyc : 0;
        end
        return r;
    endfunction

    task automatic doReset();
        rst = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its first FETCH cycle; stray acks and garbage
    // opcode/branch values are driven whenever they must be ignored
    task automatic applyStimulus(input logic [6:0] opc, input int iWait, input int dWait,
                                 input logic bt, output result_t obs);
        int fetchCnt = 0;
        int memCnt = 0;
        bit done = 0;
        obs.trap = 0; obs.cycles = 0; obs.irCnt = 0; obs.rfWe = 0;
        obs.wbSel = 0; obs.pcSrc = 0; obs.memCycles = 0; obs.weCycles = 0;
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            op_code = (state == 3'd1) ? opc : 7'($urandom);
            branch_taken = pc_en ? bt : 1'($urandom);
            if (imem_req) begin
                imem_ack = (fetchCnt == iWait);
                fetchCnt++;
            end else begin
                imem_ack = 1'($urandom);
            end
            if (dmem_req) begin
                dmem_ack = (memCnt == dWait);
                memCnt++;
            end else begin
                dmem_ack = 1'($urandom);
            end
            @(negedge clk);
            if (ir_en) obs.irCnt++;
            if (dmem_req) obs.memCycles++;
            if (dmem_we) obs.weCycles++;
            if (pc_en) begin
                obs.rfWe = rf_we;
                obs.wbSel = int'(wb_sel);
                obs.pcSrc = int'(pc_src);
                obs.cycles = cyc;
                done = 1;
            end else if (trap) begin
                obs.trap = 1;
                obs.cycles = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL instrTimeout got no WB or TRAP want completion within 100 cycles");
        end
    endtask

    task automatic checkObs(input string tag, input result_t e, input result_t o);
        checkOutput({tag, ".trap"}, int'(o.trap), int'(e.trap));
        checkOutput({tag, ".cycles"}, o.cycles, e.cycles);
        if (!e.trap) begin
            checkOutput({tag, ".irEn"}, o.irCnt, e.irCnt);
            checkOutput({tag, ".rfWe"}, int'(o.rfWe), int'(e.rfWe));
            checkOutput({tag, ".wbSel"}, o.wbSel, e.wbSel);
            checkOutput({tag, ".pcSrc"}, o.pcSrc, e.pcSrc);
            checkOutput({tag, ".memCycles"}, o.memCycles, e.memCycles);
            checkOutput({tag, ".weCycles"}, o.weCycles, e.weCycles);
        end
    endtask

    // Main sequence: reset, fixed trace, vector table, corner sequences, random run
    initial begin
        vec_t    vecs[$];
        result_t obs;
        result_t exp;
        int      expState[5] = '{0, 1, 2, 4, 0};
        int      expIr[5]    = '{1, 0, 0, 0, 1};
        int      expPc[5]    = '{0, 0, 0, 1, 0};
        int      expRf[5]    = '{0, 0, 0, 1, 0};
        bit      found;
        logic [6:0] rOpc;
        int      rI;
        int      rD;
        logic    rBt;
        logic [6:0] legalOps[9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

        //            opc          iW  dW  bt    trap cyc rf wb pc mem we
        vecs.push_back(mkVec(7'b0110011,  0,  0, 1'b0, 0,  4, 1, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0000011,  0,  3, 1'b0, 0,  8, 1, 1, 0,  4,  0));
        vecs.push_back(mkVec(7'b0100011,  1,  0, 1'b0, 0,  6, 0, 0, 0,  1,  1));
        vecs.push_back(mkVec(7'b1100011,  0,  0, 1'b1, 0,  4, 0, 0, 1,  0,  0));
        vecs.push_back(mkVec(7'b1100011,  0,  0, 1'b0, 0,  4, 0, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b1101111,  0,  0, 1'b0, 0,  4, 1, 2, 1,  0,  0));
        vecs.push_back(mkVec(7'b1100111,  0,  0, 1'b1, 0,  4, 1, 2, 2,  0,  0));
        vecs.push_back(mkVec(7'b0110111,  2,  0, 1'b0, 0,  6, 1, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0010111,  0,  0, 1'b1, 0,  4, 1, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0010011,  0,  5, 1'b0, 0,  4, 1, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0110011, 15,  0, 1'b0, 0, 19, 1, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0110011, 16,  0, 1'b0, 1, 17, 0, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0000011,  0, 15, 1'b0, 0, 20, 1, 1, 0, 16,  0));
        vecs.push_back(mkVec(7'b0100011,  0, 16, 1'b0, 1, 20, 0, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b1111111,  0,  0, 1'b0, 1,  3, 0, 0, 0,  0,  0));
        vecs.push_back(mkVec(7'b0000000,  1,  0, 1'b0, 1,  4, 0, 0, 0,  0,  0));

        // Reset: outputs all zero even with acks asserted
        rst = 1'b0;
        op_code = 7'b0110011;
        branch_taken = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutputs",
                    int'({imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_src, rf_we, wb_sel, trap, state}), 0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reqBeforeFirstEdge", int'(imem_req), 0);
        @(posedge clk);
        #1;
        checkOutput("reqAfterFirstEdge", int'(imem_req), 1);
        checkOutput("stateAfterRelease", int'(state), 0);

        // OP with immediate acks: cycle-by-cycle trace
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        op_code = 7'b0110011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("opTrace%0d.state", c), int'(state), expState[c]);
            checkOutput($sformatf("opTrace%0d.irEn", c), int'(ir_en), expIr[c]);
            checkOutput($sformatf("opTrace%0d.pcEn", c), int'(pc_en), expPc[c]);
            checkOutput($sformatf("opTrace%0d.rfWe", c), int'(rf_we), expRf[c]);
            if (c == 3) begin
                checkOutput("opTrace.wbSel", int'(wb_sel), 0);
                checkOutput("opTrace.pcSrc", int'(pc_src), 0);
            end
            @(posedge clk);
            #1;
        end
        doReset();

        // Table of instruction vectors
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].opc, vecs[i].iWait, vecs[i].dWait, vecs[i].bt, obs);
            checkObs($sformatf("vec%0d", i), vecs[i].exp, obs);
            if (obs.trap || vecs[i].exp.trap) doReset();
        end

        // Illegal opcode: trap is absorbing and ignores a stream of acks
        applyStimulus(7'b1111111, 0, 0, 1'b0, obs);
        checkOutput("illegal.trap", int'(obs.trap), 1);
        checkOutput("illegal.cycles", obs.cycles, 3);
        for (int k = 0; k < 20; k++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            op_code = 7'b0000011;
            @(negedge clk);
            checkOutput($sformatf("trapHold%0d", k),
                        int'({trap, state, imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we}),
                        int'({1'b1, 3'd7, 6'b000000}));
            @(posedge clk);
            #1;
        end
        doReset();

        // STORE interrupted by reset while in MEM
        op_code = 7'b0100011;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (dmem_req) begin
                found = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("storeReachMem", int'(found), 1);
        #2;
        checkOutput("storeMemStrobes", int'({dmem_req, dmem_we}), 3);
        rst = 1'b0;
        #1;
        checkOutput("asyncDrop", int'({dmem_req, dmem_we, imem_req, state}), 0);
        @(negedge clk);
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("storeRelease.reqBeforeEdge", int'(imem_req), 0);
        @(posedge clk);
        #1;
        checkOutput("storeRelease.fetchReq", int'({state, imem_req}), 1);

        // Randomized instructions against the reference model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rOpc = 7'($urandom);
            end else begin
                rOpc = legalOps[$urandom_range(0, 8)];
            end
            rI = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 17));
            rD = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 17));
            rBt = 1'($urandom);
            exp = expectModel(rOpc, rI, rD, rBt);
            applyStimulus(rOpc, rI, rD, rBt, obs);
            checkObs($sformatf("rand%0d_op%0h_i%0d_d%0d", n, rOpc, rI, rD), exp, obs);
            if (obs.trap || exp.trap) doReset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
